// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: arbitrates the inst/data SRAM-like ports onto one single-beat AXI master,
// keeping at most one transaction outstanding so loads always observe earlier stores.
module sram_axi_bridge #(
    parameter logic INST_ID = 1'b0,
    parameter logic DATA_ID = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic        o_inst_addr_ok,
    output logic        o_inst_data_ok,
    output logic [31:0] o_inst_rdata,
    input  logic        i_data_req,
    input  logic        i_data_wr,
    input  logic [3:0]  i_data_wstrb,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic        o_data_addr_ok,
    output logic        o_data_data_ok,
    output logic [31:0] o_data_rdata,
    output logic        o_arvalid,
    input  logic        i_arready,
    output logic [31:0] o_araddr,
    output logic        o_arid,
    input  logic        i_rvalid,
    output logic        o_rready,
    input  logic [31:0] i_rdata,
    output logic        o_awvalid,
    input  logic        i_awready,
    output logic [31:0] o_awaddr,
    output logic        o_wvalid,
    input  logic        i_wready,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    input  logic        i_bvalid,
    output logic        o_bready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_inst_rdata, r_data_rdata;
    logic [3:0]  r_wstrb;
    logic        r_arid, r_is_data, r_awvalid, r_wvalid, r_inst_data_ok, r_data_data_ok;
    logic        w_idle, w_take_data, w_take_inst, w_r_done, w_b_done, w_aw_done, w_w_done;

    assign w_idle      = r_state == IDLE;
    assign w_take_data = w_idle & i_data_req;
    assign w_take_inst = w_idle & i_inst_req & ~i_data_req;
    assign w_r_done    = (r_state == RD_DATA) & i_rvalid;
    assign w_b_done    = (r_state == WR_RESP) & i_bvalid;
    // a channel counts as done once its valid has dropped or it handshakes now
    assign w_aw_done   = ~r_awvalid | i_awready;
    assign w_w_done    = ~r_wvalid | i_wready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_take_data ? (i_data_wr ? WR_ADDR : RD_ADDR) : (w_take_inst ? RD_ADDR : IDLE);
            RD_ADDR: w_next = i_arready ? RD_DATA : RD_ADDR;
            RD_DATA: w_next = i_rvalid ? IDLE : RD_DATA;
            WR_ADDR: w_next = (w_aw_done & w_w_done) ? WR_RESP : WR_ADDR;
            WR_RESP: w_next = i_bvalid ? IDLE : WR_RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_arid         <= 1'b0;
            r_is_data      <= 1'b0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_inst_rdata   <= '0;
            r_data_rdata   <= '0;
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
        end else begin
            if (w_take_data | w_take_inst) begin
                r_addr    <= w_take_data ? i_data_addr : i_inst_addr;
                r_arid    <= w_take_data ? DATA_ID : INST_ID;
                r_is_data <= w_take_data;
                r_wdata   <= i_data_wdata;
                r_wstrb   <= i_data_wstrb;
                r_awvalid <= w_take_data & i_data_wr;
                r_wvalid  <= w_take_data & i_data_wr;
            end else begin
                if (i_awready) r_awvalid <= 1'b0;
                if (i_wready)  r_wvalid  <= 1'b0;
            end
            if (w_r_done & ~r_is_data) r_inst_rdata <= i_rdata;
            if (w_r_done & r_is_data)  r_data_rdata <= i_rdata;
            r_inst_data_ok <= w_r_done & ~r_is_data;
            r_data_data_ok <= (w_r_done & r_is_data) | w_b_done;
        end
    end

    assign o_inst_addr_ok = w_take_inst;
    assign o_data_addr_ok = w_take_data;
    assign o_inst_data_ok = r_inst_data_ok;
    assign o_data_data_ok = r_data_data_ok;
    assign o_inst_rdata   = r_inst_rdata;
    assign o_data_rdata   = r_data_rdata;
    assign o_arvalid      = r_state == RD_ADDR;
    assign o_araddr       = r_addr;
    assign o_arid         = r_arid;
    assign o_rready       = r_state == RD_DATA;
    assign o_awvalid      = r_awvalid;
    assign o_awaddr       = r_addr;
    assign o_wvalid       = r_wvalid;
    assign o_wdata        = r_wdata;
    assign o_wstrb        = r_wstrb;
    assign o_bready       = r_state == WR_RESP;
endmodule
